// File: rtl/noc_switch_allocator_if.sv
// Allocator handshake bundle: VC requests, credits, grants, crossbar selects.
// master = VC buffers / route compute side, slave = switch allocator.
interface noc_switch_allocator_if #(
  parameter int PORT_NUM = 5,
  parameter int VC_NUM   = 4
);
  localparam int PW = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1;

  logic [PORT_NUM-1:0][VC_NUM-1:0]         req_i;
  logic [PORT_NUM-1:0][VC_NUM-1:0][PW-1:0] req_port_i;
  logic [PORT_NUM-1:0][VC_NUM-1:0]         req_tail_i;
  logic [PORT_NUM-1:0]                     out_ready_i;
  logic [PORT_NUM-1:0][VC_NUM-1:0]         grant_o;
  logic [PORT_NUM-1:0]                     xbar_valid_o;
  logic [PORT_NUM-1:0][PW-1:0]             xbar_sel_o;

  modport master (
    output req_i, req_port_i, req_tail_i, out_ready_i,
    input  grant_o, xbar_valid_o, xbar_sel_o
  );

  modport slave (
    input  req_i, req_port_i, req_tail_i, out_ready_i,
    output grant_o, xbar_valid_o, xbar_sel_o
  );
endinterface

// File: rtl/noc_switch_allocator.sv
// Separable input-first switch allocator: RR VC pick per input, RR input
// pick per output, wormhole output locks, credit gating, crossbar selects.
// Ports: clk, rst_n (sync, active-low), sa (slave modport):
//   req_i/req_port_i/req_tail_i per input VC, out_ready_i per output,
//   grant_o per input VC, xbar_valid_o/xbar_sel_o per output.
// Macro SA_GRANT_REG_EN: register grant/xbar outputs (1-cycle latency).
module noc_switch_allocator #(
  parameter int PORT_NUM = 5,
  parameter int VC_NUM   = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  noc_switch_allocator_if.slave sa
);
  localparam int PW = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1;
  localparam int VW = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;

  logic [PORT_NUM-1:0][VW-1:0] vc_ptr_q, vc_ptr_d;
  logic [PORT_NUM-1:0][PW-1:0] in_ptr_q, in_ptr_d;
  logic [PORT_NUM-1:0]         lock_vld_q, lock_vld_d;
  logic [PORT_NUM-1:0][PW-1:0] lock_in_q, lock_in_d;
  logic [PORT_NUM-1:0][VW-1:0] lock_vc_q, lock_vc_d;

  logic [PORT_NUM-1:0][VC_NUM-1:0] elig;
  logic [PORT_NUM-1:0]             s1_vld;
  logic [PORT_NUM-1:0][VW-1:0]     s1_vc;
  logic [PORT_NUM-1:0][PW-1:0]     s1_port;
  logic [PORT_NUM-1:0]             s2_vld;
  logic [PORT_NUM-1:0][PW-1:0]     s2_in;

  logic [PORT_NUM-1:0][VC_NUM-1:0] gnt_c;
  logic [PORT_NUM-1:0]             xv_c;
  logic [PORT_NUM-1:0][PW-1:0]     xs_c;

  // A locked output only accepts its owning (input, VC).
  always_comb begin
    int o;
    elig = '0;
    for (int i = 0; i < PORT_NUM; i++) begin
      for (int v = 0; v < VC_NUM; v++) begin
        o = int'(sa.req_port_i[i][v]);
        if (sa.req_i[i][v] && o < PORT_NUM) begin
          if (sa.out_ready_i[o] &&
              (!lock_vld_q[o] ||
               (int'(lock_in_q[o]) == i &&
                int'(lock_vc_q[o]) == v)))
            elig[i][v] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    int v;
    s1_vld  = '0;
    s1_vc   = '0;
    s1_port = '0;
    for (int i = 0; i < PORT_NUM; i++) begin
      for (int k = 0; k < VC_NUM; k++) begin
        v = int'(vc_ptr_q[i]) + k;
        if (v >= VC_NUM) v = v - VC_NUM;
        if (!s1_vld[i] && elig[i][v]) begin
          s1_vld[i]  = 1'b1;
          s1_vc[i]   = VW'(v);
          s1_port[i] = sa.req_port_i[i][v];
        end
      end
    end
  end

  always_comb begin
    int n;
    s2_vld = '0;
    s2_in  = '0;
    for (int o = 0; o < PORT_NUM; o++) begin
      for (int k = 0; k < PORT_NUM; k++) begin
        n = int'(in_ptr_q[o]) + k;
        if (n >= PORT_NUM) n = n - PORT_NUM;
        if (!s2_vld[o] && s1_vld[n] &&
            int'(s1_port[n]) == o) begin
          s2_vld[o] = 1'b1;
          s2_in[o]  = PW'(n);
        end
      end
    end
  end

  // Only stage-2 winners move pointers or touch locks.
  always_comb begin
    int o;
    int v;
    gnt_c      = '0;
    xv_c       = s2_vld;
    xs_c       = '0;
    vc_ptr_d   = vc_ptr_q;
    in_ptr_d   = in_ptr_q;
    lock_vld_d = lock_vld_q;
    lock_in_d  = lock_in_q;
    lock_vc_d  = lock_vc_q;
    for (int p = 0; p < PORT_NUM; p++)
      if (s2_vld[p]) xs_c[p] = s2_in[p];
    for (int i = 0; i < PORT_NUM; i++) begin
      o = int'(s1_port[i]);
      v = int'(s1_vc[i]);
      if (s1_vld[i] && s2_vld[o] &&
          int'(s2_in[o]) == i) begin
        gnt_c[i][v] = 1'b1;
        vc_ptr_d[i] = VW'((v + 1) % VC_NUM);
        in_ptr_d[o] = PW'((i + 1) % PORT_NUM);
        if (!sa.req_tail_i[i][v]) begin
          lock_vld_d[o] = 1'b1;
          lock_in_d[o]  = PW'(i);
          lock_vc_d[o]  = VW'(v);
        end else begin
          // Eligibility guarantees a locked winner is the owner.
          lock_vld_d[o] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vc_ptr_q   <= '0;
      in_ptr_q   <= '0;
      lock_vld_q <= '0;
      lock_in_q  <= '0;
      lock_vc_q  <= '0;
    end else begin
      vc_ptr_q   <= vc_ptr_d;
      in_ptr_q   <= in_ptr_d;
      lock_vld_q <= lock_vld_d;
      lock_in_q  <= lock_in_d;
      lock_vc_q  <= lock_vc_d;
    end
  end

`ifdef SA_GRANT_REG_EN
  logic [PORT_NUM-1:0][VC_NUM-1:0] gnt_q;
  logic [PORT_NUM-1:0]             xv_q;
  logic [PORT_NUM-1:0][PW-1:0]     xs_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gnt_q <= '0;
      xv_q  <= '0;
      xs_q  <= '0;
    end else begin
      gnt_q <= gnt_c;
      xv_q  <= xv_c;
      xs_q  <= xs_c;
    end
  end

  assign sa.grant_o      = rst_n ? gnt_q : '0;
  assign sa.xbar_valid_o = rst_n ? xv_q  : '0;
  assign sa.xbar_sel_o   = rst_n ? xs_q  : '0;
`else
  assign sa.grant_o      = rst_n ? gnt_c : '0;
  assign sa.xbar_valid_o = rst_n ? xv_c  : '0;
  assign sa.xbar_sel_o   = rst_n ? xs_c  : '0;
`endif
endmodule
